// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen_if
//  Description : Raster timing bus from the sync generator to the window and
//                pixel-fetch logic.
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_sync_gen_if;
    logic        pix_en;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        line_start;
    logic        frame_start;

    modport master (
        output pix_en, hc, vc, hsync, vsync, blank, line_start, frame_start
    );

    modport slave (
        input  pix_en, hc, vc, hsync, vsync, blank, line_start, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : VGA raster timing generator: pixel divider, hc/vc counters,
//                horizontal/vertical phase FSMs, sync, blank and start pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_sync_gen #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_VISIBLE = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    vga_sync_gen_if.master     bus
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] c_H_ACT_LAST  = 11'(H_VISIBLE - 1);
    localparam logic [10:0] c_H_FP_LAST   = 11'(H_VISIBLE + H_FP - 1);
    localparam logic [10:0] c_H_SYNC_LAST = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] c_H_LAST      = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_V_ACT_LAST  = 11'(V_VISIBLE - 1);
    localparam logic [10:0] c_V_FP_LAST   = 11'(V_VISIBLE + V_FP - 1);
    localparam logic [10:0] c_V_SYNC_LAST = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [10:0] c_V_LAST      = 11'(c_V_TOTAL - 1);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    // Every phase must be at least one unit long or the phase FSMs skip a state.
    if (c_H_TOTAL > 2048 || c_V_TOTAL > 2048 || CLK_DIV < 1 ||
        H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("vga_sync_gen: illegal timing parameters");
    end

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_pix_en;
    logic [10:0]        r_hc;
    logic [10:0]        r_vc;
    phase_t             r_h_phase;
    phase_t             r_v_phase;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_blank;
    logic               r_line_start;
    logic               r_frame_start;

    logic               w_h_wrap;
    logic               w_v_last;
    logic [10:0]        w_hc_nxt;
    logic [10:0]        w_vc_nxt;
    phase_t             w_h_phase_nxt;
    phase_t             w_v_phase_nxt;

    assign w_h_wrap = r_pix_en && (r_hc == c_H_LAST);
    assign w_v_last = (r_vc == c_V_LAST);

    always_comb begin
        w_hc_nxt = r_hc;
        w_vc_nxt = r_vc;
        if (r_pix_en) begin
            w_hc_nxt = (r_hc == c_H_LAST) ? 11'd0 : r_hc + 11'd1;
        end
        if (w_h_wrap) begin
            w_vc_nxt = w_v_last ? 11'd0 : r_vc + 11'd1;
        end
    end

    // Phase transitions fire on the tick that moves a counter onto a boundary.
    always_comb begin
        w_h_phase_nxt = r_h_phase;
        if (r_pix_en) begin
            case (r_h_phase)
                PH_ACTIVE: if (r_hc == c_H_ACT_LAST)  w_h_phase_nxt = PH_FP;
                PH_FP:     if (r_hc == c_H_FP_LAST)   w_h_phase_nxt = PH_SYNC;
                PH_SYNC:   if (r_hc == c_H_SYNC_LAST) w_h_phase_nxt = PH_BP;
                PH_BP:     if (r_hc == c_H_LAST)      w_h_phase_nxt = PH_ACTIVE;
                default:                              w_h_phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    always_comb begin
        w_v_phase_nxt = r_v_phase;
        if (w_h_wrap) begin
            case (r_v_phase)
                PH_ACTIVE: if (r_vc == c_V_ACT_LAST)  w_v_phase_nxt = PH_FP;
                PH_FP:     if (r_vc == c_V_FP_LAST)   w_v_phase_nxt = PH_SYNC;
                PH_SYNC:   if (r_vc == c_V_SYNC_LAST) w_v_phase_nxt = PH_BP;
                PH_BP:     if (r_vc == c_V_LAST)      w_v_phase_nxt = PH_ACTIVE;
                default:                              w_v_phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with hc/vc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_pix_en      <= 1'b0;
            r_hc          <= 11'd0;
            r_vc          <= 11'd0;
            r_h_phase     <= PH_ACTIVE;
            r_v_phase     <= PH_ACTIVE;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_blank       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
            r_pix_en      <= (r_div_cnt == c_DIV_LAST);
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_h_phase     <= w_h_phase_nxt;
            r_v_phase     <= w_v_phase_nxt;
            r_hsync       <= (w_h_phase_nxt == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= (w_v_phase_nxt == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            r_blank       <= (w_h_phase_nxt != PH_ACTIVE) || (w_v_phase_nxt != PH_ACTIVE);
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap && w_v_last;
        end
    end

    assign bus.pix_en      = r_pix_en;
    assign bus.hc          = r_hc;
    assign bus.vc          = r_vc;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.blank       = r_blank;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Self-checking bench for vga_sync_gen in a small 16x8 mode
//                (both polarities, CLK_DIV=2) and the default 1024x768 mode.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vga_sync_gen_if if_s ();
    vga_sync_gen_if if_p ();
    vga_sync_gen_if if_b ();

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(2)
    ) dut_small (
        .clk(clk), .rst(rst), .bus(if_s)
    );

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(2)
    ) dut_pol (
        .clk(clk), .rst(rst), .bus(if_p)
    );

    vga_sync_gen #(
        .CLK_DIV(1)
    ) dut_big (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int fs_seen = 0;

    logic [27:0] q_s[$];
    logic [27:0] q_p[$];

    // {pix_en, hc, vc, hsync, vsync, blank, line_start, frame_start}
    function automatic logic [27:0] got_s();
        return {if_s.pix_en, if_s.hc, if_s.vc, if_s.hsync, if_s.vsync,
                if_s.blank, if_s.line_start, if_s.frame_start};
    endfunction

    function automatic logic [27:0] got_p();
        return {if_p.pix_en, if_p.hc, if_p.vc, if_p.hsync, if_p.vsync,
                if_p.blank, if_p.line_start, if_p.frame_start};
    endfunction

    function automatic logic [27:0] got_b();
        return {if_b.pix_en, if_b.hc, if_b.vc, if_b.hsync, if_b.vsync,
                if_b.blank, if_b.line_start, if_b.frame_start};
    endfunction

    // Small-mode expectation for the n-th cycle after reset release (n >= 1).
    function automatic logic [27:0] exp_small(int n, bit pol);
        int   p, h, v;
        logic pe, hs, vs, bl, ls, fs;
        p  = (n - 1) / 2;
        h  = p % 16;
        v  = (p / 16) % 8;
        pe = (n % 2 == 0);
        hs = (h >= 10 && h <= 12) ? pol : ~pol;
        vs = (v >= 5 && v <= 6) ? pol : ~pol;
        bl = (h >= 8) || (v >= 4);
        ls = (p > 0) && (h == 0) && (n % 2 == 1);
        fs = ls && (v == 0);
        return {pe, 11'(h), 11'(v), hs, vs, bl, ls, fs};
    endfunction

    task automatic release_after(int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_sb(int n0, int n1);
        logic [27:0] e, g;
        for (int n = n0; n <= n1; n++) begin
            @(posedge clk);
            q_s.push_back(exp_small(n, 1'b0));
            q_p.push_back(exp_small(n, 1'b1));
            @(negedge clk);
            e = q_s.pop_front();
            g = got_s();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL small n=%0d got=%h exp=%h", n, g, e);
            end
            e = q_p.pop_front();
            g = got_p();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL pol n=%0d got=%h exp=%h", n, g, e);
            end
            if (if_s.frame_start === 1'b1) fs_seen++;
        end
    endtask

    task automatic test_reset();
        logic [27:0] e_rst0, e_rst1;
        e_rst0 = {1'b0, 22'd0, 2'b11, 3'b000};
        e_rst1 = 28'd0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (got_s() !== e_rst0) begin
                n_err++;
                $display("FAIL reset_small got=%h exp=%h", got_s(), e_rst0);
            end
            n_vec++;
            if (got_p() !== e_rst1) begin
                n_err++;
                $display("FAIL reset_pol got=%h exp=%h", got_p(), e_rst1);
            end
            n_vec++;
            if (got_b() !== e_rst0) begin
                n_err++;
                $display("FAIL reset_big got=%h exp=%h", got_b(), e_rst0);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_line();
        run_sb(1, 40);
    endtask

    task automatic test_frame();
        fs_seen = 0;
        run_sb(41, 600);
        n_vec++;
        if (fs_seen != 2) begin
            n_err++;
            $display("FAIL frame_start_count got=%0d exp=%0d", fs_seen, 2);
        end
    endtask

    task automatic test_frame_period();
        int n, t1, t2;
        bit found;
        release_after(1);
        n = 0; t1 = -1; t2 = -1;
        found = 1'b0;
        while (!found && n < 400) begin
            @(negedge clk);
            n++;
            if (if_s.frame_start === 1'b1) begin found = 1'b1; t1 = n; end
        end
        found = 1'b0;
        while (!found && n < 800) begin
            @(negedge clk);
            n++;
            if (if_s.frame_start === 1'b1) begin found = 1'b1; t2 = n; end
        end
        n_vec++;
        if (t1 != 257) begin
            n_err++;
            $display("FAIL first_frame_start got=%0d exp=%0d", t1, 257);
        end
        n_vec++;
        if (t2 - t1 != 256 || t2 < 0) begin
            n_err++;
            $display("FAIL frame_period got=%0d exp=%0d", t2 - t1, 256);
        end
    endtask

    task automatic test_big_mode();
        int n, t1, t2;
        logic [10:0] vc1, vc2, hc1;
        logic prev;
        release_after(2);
        n = 0; t1 = -1; t2 = -1;
        vc1 = '1; vc2 = '1; hc1 = '1;
        prev = 1'b1;
        while (t2 < 0 && n < 3000) begin
            @(negedge clk);
            n++;
            if (prev === 1'b1 && if_b.hsync === 1'b0) begin
                if (t1 < 0) begin
                    t1 = n; vc1 = if_b.vc; hc1 = if_b.hc;
                end else begin
                    t2 = n; vc2 = if_b.vc;
                end
            end
            prev = if_b.hsync;
        end
        n_vec++;
        if (t1 != 1049 || hc1 !== 11'd1048) begin
            n_err++;
            $display("FAIL big_first_hsync got=%0d/%0d exp=%0d/%0d", t1, hc1, 1049, 1048);
        end
        n_vec++;
        if (t2 - t1 != 1344 || t2 < 0) begin
            n_err++;
            $display("FAIL big_hsync_period got=%0d exp=%0d", t2 - t1, 1344);
        end
        n_vec++;
        if (vc1 !== 11'd0 || vc2 !== 11'd1) begin
            n_err++;
            $display("FAIL big_vc_step got=%0d,%0d exp=0,1", vc1, vc2);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [27:0] e_rst0, e_rst1;
        e_rst0 = {1'b0, 22'd0, 2'b11, 3'b000};
        e_rst1 = 28'd0;
        release_after(1);
        run_sb(1, 183);
        n_vec++;
        if (if_s.hc !== 11'd11 || if_s.vc !== 11'd5 || if_s.hsync !== 1'b0 || if_s.vsync !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_setup got=%0d/%0d/%b%b exp=11/5/00",
                     if_s.hc, if_s.vc, if_s.hsync, if_s.vsync);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (got_s() !== e_rst0) begin
            n_err++;
            $display("FAIL midframe_reset_small got=%h exp=%h", got_s(), e_rst0);
        end
        n_vec++;
        if (got_p() !== e_rst1) begin
            n_err++;
            $display("FAIL midframe_reset_pol got=%h exp=%h", got_p(), e_rst1);
        end
        run_sb(1, 40);
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_frame_period();
        test_big_mode();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
